// File: rtl/fpu_result_packer.sv
// Final FP add/sub result packer: exponent overflow/underflow classification, IEEE word packing,
// two-stage elastic pipeline, sticky flags and saturating counters. Optional: OVF_SATURATE_EN.
module fpu_result_packer #(
    parameter int W     = 32,
    parameter int W_Exp = 9,
    parameter int W_Sgf = 23,
    parameter int W_Cnt = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic             sign_i,
    input  logic [W_Exp-1:0] exp_i,
    input  logic [W_Sgf-1:0] sgf_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [W-1:0]     result_o,
    output logic             ovf_o,
    output logic             unf_o,
    output logic             sticky_ovf_o,
    output logic             sticky_unf_o,
    input  logic             clr_sticky_i,
    output logic [W_Cnt-1:0] ovf_cnt_o,
    output logic [W_Cnt-1:0] unf_cnt_o
);

    localparam logic [W_Exp-1:0] EXP_ONE  = {{(W_Exp-1){1'b0}}, 1'b1};
    localparam logic [W_Exp-1:0] EXP_MAX  = {1'b0, {(W_Exp-1){1'b1}}};
    localparam logic [W_Exp-1:0] U_LIMIT  = EXP_MAX - EXP_ONE;
    localparam logic [W_Exp-1:0] L_LIMIT  = EXP_ONE;
    localparam logic [W_Cnt-1:0] CNT_ONE  = {{(W_Cnt-1){1'b0}}, 1'b1};

    // Overflow is checked first so an exponent can never raise both flags.
    function automatic logic [W-1:0] pack_result(
        input logic             s,
        input logic [W_Exp-2:0] e,
        input logic [W_Sgf-1:0] f,
        input logic             ovf,
        input logic             unf
    );
        logic [W-1:0] r;
        if (ovf) begin
`ifdef OVF_SATURATE_EN
            r = {s, U_LIMIT[W_Exp-2:0], {W_Sgf{1'b1}}};
`else
            r = {s, {(W_Exp-1){1'b1}}, {W_Sgf{1'b0}}};
`endif
        end else if (unf) begin
            r = {s, {(W-1){1'b0}}};
        end else begin
            r = {s, e, f};
        end
        return r;
    endfunction

    function automatic logic [W_Cnt-1:0] sat_inc(input logic [W_Cnt-1:0] c);
        return (&c) ? c : c + CNT_ONE;
    endfunction

    logic             r_vld_p1;
    logic             r_sign_p1;
    logic [W_Exp-2:0] r_exp_p1;
    logic [W_Sgf-1:0] r_sgf_p1;
    logic             r_ovf_p1;
    logic             r_unf_p1;

    logic             r_vld_p2;
    logic [W-1:0]     r_result_p2;
    logic             r_ovf_p2;
    logic             r_unf_p2;

    logic             r_sticky_ovf;
    logic             r_sticky_unf;
    logic [W_Cnt-1:0] r_ovf_cnt;
    logic [W_Cnt-1:0] r_unf_cnt;

    logic             w_load_p2;
    logic             w_in_ready;
    logic             w_xfer;
    logic             w_ovf;
    logic             w_unf;

    assign w_load_p2  = !r_vld_p2 || out_ready_i;
    assign w_in_ready = !r_vld_p1 || w_load_p2;
    assign w_xfer     = r_vld_p2 && out_ready_i;
    assign w_ovf      = exp_i > U_LIMIT;
    assign w_unf      = !w_ovf && (exp_i < L_LIMIT);

    // Stage 1: capture and classify
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p1  <= 1'b0;
            r_sign_p1 <= 1'b0;
            r_exp_p1  <= '0;
            r_sgf_p1  <= '0;
            r_ovf_p1  <= 1'b0;
            r_unf_p1  <= 1'b0;
        end else if (w_in_ready) begin
            r_vld_p1 <= in_valid_i;
            if (in_valid_i) begin
                r_sign_p1 <= sign_i;
                r_exp_p1  <= exp_i[W_Exp-2:0];
                r_sgf_p1  <= sgf_i;
                r_ovf_p1  <= w_ovf;
                r_unf_p1  <= w_unf;
            end
        end
    end

    // Stage 2: pack; data holds while the output is stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p2    <= 1'b0;
            r_result_p2 <= '0;
            r_ovf_p2    <= 1'b0;
            r_unf_p2    <= 1'b0;
        end else if (w_load_p2) begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                r_result_p2 <= pack_result(r_sign_p1, r_exp_p1, r_sgf_p1, r_ovf_p1, r_unf_p1);
                r_ovf_p2    <= r_ovf_p1;
                r_unf_p2    <= r_unf_p1;
            end
        end
    end

    // Exception bookkeeping counts delivered results only; clear beats a same-cycle event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sticky_ovf <= 1'b0;
            r_sticky_unf <= 1'b0;
            r_ovf_cnt    <= '0;
            r_unf_cnt    <= '0;
        end else if (clr_sticky_i) begin
            r_sticky_ovf <= 1'b0;
            r_sticky_unf <= 1'b0;
            r_ovf_cnt    <= '0;
            r_unf_cnt    <= '0;
        end else if (w_xfer) begin
            if (r_ovf_p2) begin
                r_sticky_ovf <= 1'b1;
                r_ovf_cnt    <= sat_inc(r_ovf_cnt);
            end
            if (r_unf_p2) begin
                r_sticky_unf <= 1'b1;
                r_unf_cnt    <= sat_inc(r_unf_cnt);
            end
        end
    end

    assign in_ready_o   = w_in_ready;
    assign out_valid_o  = r_vld_p2;
    assign result_o     = r_result_p2;
    assign ovf_o        = r_ovf_p2;
    assign unf_o        = r_unf_p2;
    assign sticky_ovf_o = r_sticky_ovf;
    assign sticky_unf_o = r_sticky_unf;
    assign ovf_cnt_o    = r_ovf_cnt;
    assign unf_cnt_o    = r_unf_cnt;

endmodule

// File: tb/tb_fpu_result_packer.sv
// Directed bench for fpu_result_packer (single precision), honouring OVF_SATURATE_EN.
module tb_fpu_result_packer;

`ifdef OVF_SATURATE_EN
    localparam logic [31:0] POS_OVF = 32'h7F7FFFFF;
    localparam logic [31:0] NEG_OVF = 32'hFF7FFFFF;
`else
    localparam logic [31:0] POS_OVF = 32'h7F800000;
    localparam logic [31:0] NEG_OVF = 32'hFF800000;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic        sign_i = 1'b0;
    logic [8:0]  exp_i = '0;
    logic [22:0] sgf_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b1;
    logic [31:0] result_o;
    logic        ovf_o;
    logic        unf_o;
    logic        sticky_ovf_o;
    logic        sticky_unf_o;
    logic        clr_sticky_i = 1'b0;
    logic [7:0]  ovf_cnt_o;
    logic [7:0]  unf_cnt_o;

    int checks = 0;
    int errors = 0;

    fpu_result_packer #(.W(32), .W_Exp(9), .W_Sgf(23), .W_Cnt(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .sign_i(sign_i), .exp_i(exp_i), .sgf_i(sgf_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .result_o(result_o), .ovf_o(ovf_o), .unf_o(unf_o),
        .sticky_ovf_o(sticky_ovf_o), .sticky_unf_o(sticky_unf_o),
        .clr_sticky_i(clr_sticky_i),
        .ovf_cnt_o(ovf_cnt_o), .unf_cnt_o(unf_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one beat and returns one step after the edge that accepted it.
    task automatic send(input logic s, input logic [8:0] e, input logic [22:0] f, output bit ok);
        sign_i = s; exp_i = e; sgf_i = f; in_valid_i = 1'b1; ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (in_ready_o) begin
                ok = 1'b1;
                tick();
                break;
            end
            tick();
        end
        in_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", out_valid_o); end
        checks++; if (result_o !== 32'h0) begin errors++; $display("FAIL rst_result got %h want 0", result_o); end
        checks++; if ({ovf_o, unf_o, sticky_ovf_o, sticky_unf_o} !== 4'b0) begin errors++; $display("FAIL rst_flags got %b want 0000", {ovf_o, unf_o, sticky_ovf_o, sticky_unf_o}); end
        checks++; if ({ovf_cnt_o, unf_cnt_o} !== 16'h0) begin errors++; $display("FAIL rst_cnt got %h want 0000", {ovf_cnt_o, unf_cnt_o}); end
        rst = 1'b0;
        tick();
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", in_ready_o); end
    endtask

    task automatic test_normal();
        bit ok;
        out_ready_i = 1'b1;
        send(1'b0, 9'h07F, 23'h0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL norm_accept got timeout want accept"); end
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL norm_lat1 got %b want 0", out_valid_o); end
        tick();
        checks++; if (out_valid_o !== 1'b1) begin errors++; $display("FAIL norm_lat2 got %b want 1", out_valid_o); end
        checks++; if (result_o !== 32'h3F800000) begin errors++; $display("FAIL norm_result got %h want 3f800000", result_o); end
        checks++; if ({ovf_o, unf_o} !== 2'b00) begin errors++; $display("FAIL norm_flags got %b want 00", {ovf_o, unf_o}); end
        tick();
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL norm_drain got %b want 0", out_valid_o); end
        checks++; if (ovf_cnt_o !== 8'd0) begin errors++; $display("FAIL norm_cnt got %h want 00", ovf_cnt_o); end
    endtask

    task automatic test_overflow();
        bit ok;
        send(1'b1, 9'h0FF, 23'h123456, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ovf_accept got timeout want accept"); end
        tick();
        checks++; if (result_o !== NEG_OVF) begin errors++; $display("FAIL ovf_result got %h want %h", result_o, NEG_OVF); end
        checks++; if ({ovf_o, unf_o} !== 2'b10) begin errors++; $display("FAIL ovf_flags got %b want 10", {ovf_o, unf_o}); end
        checks++; if (sticky_ovf_o !== 1'b0) begin errors++; $display("FAIL ovf_sticky_early got %b want 0", sticky_ovf_o); end
        tick();
        checks++; if (sticky_ovf_o !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", sticky_ovf_o); end
        checks++; if (ovf_cnt_o !== 8'd1) begin errors++; $display("FAIL ovf_cnt got %h want 01", ovf_cnt_o); end
    endtask

    task automatic test_underflow();
        bit ok;
        send(1'b1, 9'h000, 23'h7FFFFF, ok);
        tick();
        checks++; if (result_o !== 32'h80000000) begin errors++; $display("FAIL unf_result got %h want 80000000", result_o); end
        checks++; if ({ovf_o, unf_o} !== 2'b01) begin errors++; $display("FAIL unf_flags got %b want 01", {ovf_o, unf_o}); end
        send(1'b0, 9'h1FF, 23'h0, ok);
        checks++; if ({sticky_unf_o, unf_cnt_o} !== {1'b1, 8'd1}) begin errors++; $display("FAIL unf_sticky got %b/%h want 1/01", sticky_unf_o, unf_cnt_o); end
        tick();
        checks++; if (result_o !== POS_OVF) begin errors++; $display("FAIL big_exp_result got %h want %h", result_o, POS_OVF); end
        checks++; if ({ovf_o, unf_o} !== 2'b10) begin errors++; $display("FAIL big_exp_flags got %b want 10", {ovf_o, unf_o}); end
        tick();
        checks++; if (ovf_cnt_o !== 8'd2) begin errors++; $display("FAIL big_exp_cnt got %h want 02", ovf_cnt_o); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        out_ready_i = 1'b0;
        send(1'b0, 9'h080, 23'h0, ok);
        send(1'b0, 9'h081, 23'h0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_accept2 got timeout want accept"); end
        checks++; if (out_valid_o !== 1'b1 || result_o !== 32'h40000000) begin errors++; $display("FAIL bp_first got %b/%h want 1/40000000", out_valid_o, result_o); end
        checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready got %b want 0", in_ready_o); end
        sign_i = 1'b0; exp_i = 9'h082; sgf_i = 23'h0; in_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (out_valid_o !== 1'b1 || result_o !== 32'h40000000 || in_ready_o !== 1'b0) begin
                errors++; $display("FAIL bp_hold%0d got %b/%h/%b want 1/40000000/0", i, out_valid_o, result_o, in_ready_o);
            end
        end
        out_ready_i = 1'b1;
        #1;
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b want 1", in_ready_o); end
        tick();
        in_valid_i = 1'b0;
        checks++; if (out_valid_o !== 1'b1 || result_o !== 32'h40800000) begin errors++; $display("FAIL bp_second got %b/%h want 1/40800000", out_valid_o, result_o); end
        tick();
        checks++; if (out_valid_o !== 1'b1 || result_o !== 32'h41000000) begin errors++; $display("FAIL bp_third got %b/%h want 1/41000000", out_valid_o, result_o); end
        tick();
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL bp_drain got %b want 0", out_valid_o); end
    endtask

    task automatic test_saturate();
        bit ok;
        clr_sticky_i = 1'b1;
        tick();
        clr_sticky_i = 1'b0;
        checks++; if ({sticky_ovf_o, sticky_unf_o, ovf_cnt_o, unf_cnt_o} !== 18'h0) begin
            errors++; $display("FAIL clr got %b%b/%h/%h want 00/00/00", sticky_ovf_o, sticky_unf_o, ovf_cnt_o, unf_cnt_o);
        end
        out_ready_i = 1'b1;
        sign_i = 1'b0; exp_i = 9'h0FF; sgf_i = 23'h0; in_valid_i = 1'b1;
        repeat (260) tick();
        in_valid_i = 1'b0;
        repeat (3) tick();
        checks++; if (ovf_cnt_o !== 8'hFF) begin errors++; $display("FAIL sat_cnt got %h want ff", ovf_cnt_o); end
        checks++; if (sticky_ovf_o !== 1'b1 || unf_cnt_o !== 8'h00) begin errors++; $display("FAIL sat_sticky got %b/%h want 1/00", sticky_ovf_o, unf_cnt_o); end
        send(1'b1, 9'h1FF, 23'h0, ok);
        tick();
        checks++; if (out_valid_o !== 1'b1 || result_o !== NEG_OVF) begin errors++; $display("FAIL clr_beat got %b/%h want 1/%h", out_valid_o, result_o, NEG_OVF); end
        clr_sticky_i = 1'b1;
        tick();
        clr_sticky_i = 1'b0;
        checks++; if (ovf_cnt_o !== 8'h00 || sticky_ovf_o !== 1'b0) begin errors++; $display("FAIL clr_wins got %h/%b want 00/0", ovf_cnt_o, sticky_ovf_o); end
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL clr_drain got %b want 0", out_valid_o); end
    endtask

    task automatic test_reset_midstream();
        out_ready_i = 1'b1;
        sign_i = 1'b0; exp_i = 9'h0FF; sgf_i = 23'h0; in_valid_i = 1'b1;
        repeat (3) tick();
        in_valid_i = 1'b0;
        checks++; if (out_valid_o !== 1'b1 || ovf_cnt_o !== 8'd1) begin errors++; $display("FAIL mid_pre got %b/%h want 1/01", out_valid_o, ovf_cnt_o); end
        rst = 1'b1;
        #1;
        checks++; if (out_valid_o !== 1'b0 || result_o !== 32'h0 || ovf_o !== 1'b0) begin errors++; $display("FAIL mid_rst_out got %b/%h/%b want 0/0/0", out_valid_o, result_o, ovf_o); end
        checks++; if (ovf_cnt_o !== 8'h0 || sticky_ovf_o !== 1'b0) begin errors++; $display("FAIL mid_rst_cnt got %h/%b want 00/0", ovf_cnt_o, sticky_ovf_o); end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL mid_stale%0d got %b want 0", i, out_valid_o); end
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_overflow();
        test_underflow();
        test_back_to_back();
        test_saturate();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
